// File: rtl/enc_parity_stage.sv
// Second stage of the multi-mode extended-Hamming encoder: computes the overall
// even parity over the mode's codeword, inserts it at its slot and zero-pads above.
module enc_parity_stage #(
    parameter int MAX_CODEWORD_WIDTH = 32,
    parameter int CW_WIDTH_1         = 8,
    parameter int CW_WIDTH_2         = 16,
    parameter int CW_WIDTH_3         = 32,
    parameter int PAR_WIDTH_1        = 4,
    parameter int PAR_WIDTH_2        = 5,
    parameter int PAR_WIDTH_3        = 6,
    parameter int CNT_WIDTH          = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [MAX_CODEWORD_WIDTH-1:0] data_in,
    input  logic [1:0]                    work_mod,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [MAX_CODEWORD_WIDTH-1:0] data_out,
    output logic [1:0]                    out_mode,
    output logic                          out_err,
    input  logic                          cnt_clr,
    output logic [CNT_WIDTH-1:0]          enc_count
);

    localparam int W = MAX_CODEWORD_WIDTH;

    typedef enum logic [1:0] {
        MODE_1   = 2'b00,
        MODE_2   = 2'b01,
        MODE_3   = 2'b10,
        MODE_BAD = 2'b11
    } mode_e;

    function automatic logic [W-1:0] low_mask(input int n);
        logic [W-1:0] m;
        for (int i = 0; i < W; i++) m[i] = (i < n);
        return m;
    endfunction

    localparam logic [W-1:0] CW_MASK_1   = low_mask(CW_WIDTH_1);
    localparam logic [W-1:0] CW_MASK_2   = low_mask(CW_WIDTH_2);
    localparam logic [W-1:0] CW_MASK_3   = low_mask(CW_WIDTH_3);
    localparam logic [W-1:0] SLOT_MASK_1 = low_mask(PAR_WIDTH_1) ^ low_mask(PAR_WIDTH_1 - 1);
    localparam logic [W-1:0] SLOT_MASK_2 = low_mask(PAR_WIDTH_2) ^ low_mask(PAR_WIDTH_2 - 1);
    localparam logic [W-1:0] SLOT_MASK_3 = low_mask(PAR_WIDTH_3) ^ low_mask(PAR_WIDTH_3 - 1);

    // The illegal mode maps to empty masks, so its word collapses to zero naturally.
    function automatic logic [W-1:0] cw_mask_of(input mode_e m);
        case (m)
            MODE_1:  return CW_MASK_1;
            MODE_2:  return CW_MASK_2;
            MODE_3:  return CW_MASK_3;
            default: return '0;
        endcase
    endfunction

    function automatic logic [W-1:0] slot_mask_of(input mode_e m);
        case (m)
            MODE_1:  return SLOT_MASK_1;
            MODE_2:  return SLOT_MASK_2;
            MODE_3:  return SLOT_MASK_3;
            default: return '0;
        endcase
    endfunction

    logic                 s1_valid_q, s1_valid_d;
    logic [W-1:0]         s1_data_q, s1_data_d;
    logic                 s1_par_q, s1_par_d;
    mode_e                s1_mode_q;
    logic                 s2_valid_q;
    logic [W-1:0]         s2_data_q, s2_data_d;
    mode_e                s2_mode_q;
    logic                 s2_err_q;
    logic [CNT_WIDTH-1:0] count_q;

    logic s2_load, s1_to_s2, in_fire, out_fire;

    assign s2_load  = !s2_valid_q || out_ready;
    assign s1_to_s2 = s1_valid_q && s2_load;
    assign in_ready = !s1_valid_q || s2_load;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = s2_valid_q && out_ready;

    // NOTE: combinational blocks use blocking assignments and give every output a default first, so no latch is inferred.
    always_comb begin
        s1_valid_d = s1_valid_q;
        if (in_ready) s1_valid_d = in_valid;
        s1_data_d  = data_in & cw_mask_of(mode_e'(work_mod)) & ~slot_mask_of(mode_e'(work_mod));
        s1_par_d   = ^s1_data_d;
        s2_data_d  = s1_data_q | (s1_par_q ? slot_mask_of(s1_mode_q) : '0);
    end

    // NOTE: state uses non-blocking assignments; the datapath registers are reset too because a zero data_out after reset is visible behaviour.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_par_q   <= 1'b0;
            s1_mode_q  <= MODE_1;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_mode_q  <= MODE_1;
            s2_err_q   <= 1'b0;
            count_q    <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            if (in_fire) begin
                s1_data_q <= s1_data_d;
                s1_par_q  <= s1_par_d;
                s1_mode_q <= mode_e'(work_mod);
            end
            if (s2_load) s2_valid_q <= s1_valid_q;
            if (s1_to_s2) begin
                s2_data_q <= s2_data_d;
                s2_mode_q <= s1_mode_q;
                s2_err_q  <= (s1_mode_q == MODE_BAD);
            end
            if (cnt_clr) begin
                count_q <= '0;
            end else if (out_fire && count_q != '1) begin
                count_q <= count_q + 1'b1;
            end
        end
    end

    assign out_valid = s2_valid_q;
    assign data_out  = s2_data_q;
    assign out_mode  = s2_mode_q;
    assign out_err   = s2_err_q;
    assign enc_count = count_q;

endmodule

// File: tb/tb_enc_parity_stage.sv
// Directed bench for enc_parity_stage: parity insertion per mode, illegal mode,
// backpressure, mid-flight reset and counter clear priority.
module tb_enc_parity_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] data_in;
    logic [1:0]  work_mod;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] data_out;
    logic [1:0]  out_mode;
    logic        out_err;
    logic        cnt_clr;
    logic [15:0] enc_count;

    int checks   = 0;
    int failures = 0;

    enc_parity_stage dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .work_mod  (work_mod),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out),
        .out_mode  (out_mode),
        .out_err   (out_err),
        .cnt_clr   (cnt_clr),
        .enc_count (enc_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [1:0] m, input logic [31:0] d);
        in_valid = 1'b1;
        work_mod = m;
        data_in  = d;
    endtask

    // One isolated word: accept, wait for S2, check, then let it drain.
    task automatic single(input string tag, input logic [1:0] m, input logic [31:0] d,
                          input logic [31:0] exp_data, input logic exp_err);
        drive(m, d);
        tick();
        in_valid = 1'b0;
        check({tag, "_lat1_valid"}, 32'(out_valid), 32'd0);
        tick();
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_data"}, data_out, exp_data);
        check({tag, "_mode"}, 32'(out_mode), 32'(m));
        check({tag, "_err"}, 32'(out_err), 32'(exp_err));
        tick();
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; data_in = '0; work_mod = 2'b00;
        out_ready = 1'b1; cnt_clr = 1'b0;
        tick(); tick();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_data_out", data_out, 32'd0);
        check("rst_out_err", 32'(out_err), 32'd0);
        check("rst_count", 32'(enc_count), 32'd0);
        rst = 1'b0;
        tick();
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        single("m00_f7", 2'b00, 32'h0000_00F7, 32'h0000_00FF, 1'b0);
        single("m01_ffff0001", 2'b01, 32'hFFFF_0001, 32'h0000_0011, 1'b0);
        single("m10_ones", 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        single("m10_slot_ignored", 2'b10, 32'h0000_0020, 32'h0000_0000, 1'b0);
        check("count_after_4", 32'(enc_count), 32'd4);

        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        check("count_clr", 32'(enc_count), 32'd0);

        // Back-to-back 00, 11, 10 with no bubbles.
        drive(2'b00, 32'h0000_00F7);
        tick();
        drive(2'b11, 32'h1234_5678);
        check("b2b_in_ready", 32'(in_ready), 32'd1);
        tick();
        drive(2'b10, 32'hFFFF_FFFF);
        check("b2b_w1_data", data_out, 32'h0000_00FF);
        check("b2b_w1_mode", 32'(out_mode), 32'd0);
        tick();
        in_valid = 1'b0;
        check("b2b_w2_valid", 32'(out_valid), 32'd1);
        check("b2b_w2_data", data_out, 32'h0000_0000);
        check("b2b_w2_err", 32'(out_err), 32'd1);
        check("b2b_w2_mode", 32'(out_mode), 32'd3);
        tick();
        check("b2b_w3_data", data_out, 32'hFFFF_FFFF);
        check("b2b_w3_err", 32'(out_err), 32'd0);
        check("b2b_w3_mode", 32'(out_mode), 32'd2);
        tick();
        check("b2b_drained", 32'(out_valid), 32'd0);
        check("b2b_count", 32'(enc_count), 32'd3);

        // Backpressure: two words held, the third waits for out_ready.
        out_ready = 1'b0;
        drive(2'b01, 32'h0000_0003);
        check("bp_a_ready", 32'(in_ready), 32'd1);
        tick();
        drive(2'b00, 32'h0000_0001);
        check("bp_b_ready", 32'(in_ready), 32'd1);
        tick();
        drive(2'b10, 32'h0000_0007);
        check("bp_c_blocked", 32'(in_ready), 32'd0);
        tick();
        check("bp_c_still_blocked", 32'(in_ready), 32'd0);
        check("bp_a_held_valid", 32'(out_valid), 32'd1);
        check("bp_a_held_data", data_out, 32'h0000_0003);
        tick();
        check("bp_a_stable_data", data_out, 32'h0000_0003);
        check("bp_a_stable_mode", 32'(out_mode), 32'd1);
        check("bp_count_held", 32'(enc_count), 32'd3);
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        check("bp_b_data", data_out, 32'h0000_0009);
        check("bp_b_mode", 32'(out_mode), 32'd0);
        tick();
        check("bp_c_data", data_out, 32'h0000_0027);
        check("bp_c_mode", 32'(out_mode), 32'd2);
        tick();
        check("bp_drained", 32'(out_valid), 32'd0);
        check("bp_count", 32'(enc_count), 32'd6);

        // Reset with two words in flight.
        out_ready = 1'b0;
        drive(2'b00, 32'h0000_00F7);
        tick();
        drive(2'b01, 32'h0000_0001);
        tick();
        in_valid = 1'b0;
        check("mid_rst_inflight", 32'(out_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_count", 32'(enc_count), 32'd0);
        check("mid_rst_data", data_out, 32'd0);
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        tick();
        check("post_mid_rst_idle1", 32'(out_valid), 32'd0);
        tick();
        check("post_mid_rst_idle2", 32'(out_valid), 32'd0);

        // Clear beats a simultaneous output handshake.
        single("pre_clr", 2'b00, 32'h0000_00F7, 32'h0000_00FF, 1'b0);
        check("pre_clr_count", 32'(enc_count), 32'd1);
        drive(2'b01, 32'hFFFF_0001);
        tick();
        in_valid = 1'b0;
        tick();
        check("clr_hs_valid", 32'(out_valid), 32'd1);
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        check("clr_hs_count", 32'(enc_count), 32'd0);
        check("clr_hs_drained", 32'(out_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
